// File: rtl/genius_seq_gen_if.sv
// Control and read-port bundle for the Genius sequence generator.
// The master side (game controller) requests appends and reads steps back.
// The slave side is the generator.
interface genius_seq_gen_if #(
    parameter int N_COLORS = 4,
    parameter int DEPTH    = 32
);
    localparam int AW = $clog2(DEPTH);

    logic                new_game;
    logic                append;
    logic [AW-1:0]       rd_addr;
    logic [N_COLORS-1:0] rd_color;
    logic [AW:0]         seq_len;
    logic                full;
    logic                busy;
    logic                append_done;

    modport master (
        output new_game, append, rd_addr,
        input  rd_color, seq_len, full, busy, append_done
    );

    modport slave (
        input  new_game, append, rd_addr,
        output rd_color, seq_len, full, busy, append_done
    );
endinterface

// File: rtl/genius_seq_gen.sv
// Genius colour sequence generator.
// A free-running Galois LFSR supplies random colours, and each append stores
// one colour in a sequence RAM. An optional rule stops the same colour from
// appearing three times in a row. Steps are read back one-hot with one cycle
// of latency, and reads at or beyond the current length return zero.
module genius_seq_gen #(
    parameter int          N_COLORS  = 4,
    parameter int          DEPTH     = 32,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          NO_TRIPLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    genius_seq_gen_if.slave  bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = $clog2(N_COLORS);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] TWO_L   = (AW+1)'(2);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t              state, state_nx;
    logic [15:0]         lfsr;
    logic [CW-1:0]       cand;
    logic [CW-1:0]       col;
    logic [CW-1:0]       hist1;
    logic [CW-1:0]       hist2;
    logic [AW:0]         seq_len;
    logic                full;
    logic                done;
    logic [N_COLORS-1:0] rd_color;
    logic                start;
    logic                commit;
    logic [CW-1:0]       mem [DEPTH];

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state. new_game cancels both a pending start and an in-flight commit.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.append && !full && !bus.new_game) begin
                    state_nx = WRITE;
                    start    = 1'b1;
                end
            end
            WRITE: begin
                state_nx = IDLE;
                commit   = !bus.new_game;
            end
            default: state_nx = IDLE;
        endcase
        if (bus.new_game) state_nx = IDLE;
    end

    // Free-running Galois LFSR (x^16+x^14+x^13+x^11+1). It recovers from the all-zero state.
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= SEED;
        else if (lfsr == '0)
            lfsr <= 16'h0001;
        else
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // No-triple rule. The history registers hold the last two written colours.
    always_comb begin
        col = cand;
        if (NO_TRIPLE != 0 && seq_len >= TWO_L && cand == hist1 && cand == hist2)
            col = cand + 1'b1;
    end

    // Sequence length, fullness, history and the write-done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            cand    <= '0;
            seq_len <= '0;
            full    <= 1'b0;
            done    <= 1'b0;
            hist1   <= '0;
            hist2   <= '0;
        end else begin
            done <= commit;
            if (bus.new_game) begin
                seq_len <= '0;
                full    <= 1'b0;
                hist1   <= '0;
                hist2   <= '0;
            end else if (start) begin
                cand <= lfsr[CW-1:0];
            end else if (commit) begin
                seq_len <= seq_len + 1'b1;
                full    <= (seq_len + 1'b1) == DEPTH_L;
                hist2   <= hist1;
                hist1   <= col;
            end
        end
    end

    // Sequence RAM stores colour indices. Reset is not applied here; reads are gated by seq_len.
    always_ff @(posedge clk) begin
        if (commit && !rst)
            mem[seq_len[AW-1:0]] <= col;
    end

    // Registered one-hot read port
    always_ff @(posedge clk) begin
        if (rst)
            rd_color <= '0;
        else if ({1'b0, bus.rd_addr} < seq_len)
            rd_color <= N_COLORS'(1) << mem[bus.rd_addr];
        else
            rd_color <= '0;
    end

    assign bus.rd_color    = rd_color;
    assign bus.seq_len     = seq_len;
    assign bus.full        = full;
    assign bus.busy        = (state == WRITE);
    assign bus.append_done = done;
endmodule

// File: tb/tb_genius_seq_gen.sv
// Directed bench for genius_seq_gen.
// dut0 is the default build: 4 colours, depth 32, no-triple rule on.
// dut1 is a raw build: 8 colours, depth 256, rule off.
// Both instances share the clock, reset and stimulus, and each is compared
// against its own expected-sequence queue.
module tb_genius_seq_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    genius_seq_gen_if #(.N_COLORS(4), .DEPTH(32))  a_if ();
    genius_seq_gen_if #(.N_COLORS(8), .DEPTH(256)) b_if ();

    genius_seq_gen #(.N_COLORS(4), .DEPTH(32), .SEED(16'hACE1), .NO_TRIPLE(1))
        dut0 (.clk(clk), .rst(rst), .bus(a_if));
    genius_seq_gen #(.N_COLORS(8), .DEPTH(256), .SEED(16'hACE1), .NO_TRIPLE(0))
        dut1 (.clk(clk), .rst(rst), .bus(b_if));

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [15:0] m_lfsr;
    logic [1:0]  q0[$];
    logic [2:0]  q1[$];

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        if (x == 16'h0000) return 16'h0001;
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    // Reference LFSR, stepped on the same edges as the DUTs
    always @(posedge clk) m_lfsr <= rst ? 16'hACE1 : lfsr_next(m_lfsr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] er0(input int unsigned addr);
        return (addr < q0.size()) ? (4'b0001 << q0[addr]) : 4'b0000;
    endfunction

    function automatic logic [7:0] er1(input int unsigned addr);
        return (addr < q1.size()) ? (8'b0000_0001 << q1[addr]) : 8'b0000_0000;
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rd0"},   a_if.rd_color,    0);
        chk({tag, "_len0"},  a_if.seq_len,     0);
        chk({tag, "_full0"}, a_if.full,        0);
        chk({tag, "_busy0"}, a_if.busy,        0);
        chk({tag, "_done0"}, a_if.append_done, 0);
        chk({tag, "_rd1"},   b_if.rd_color,    0);
        chk({tag, "_len1"},  b_if.seq_len,     0);
        chk({tag, "_busy1"}, b_if.busy,        0);
        chk({tag, "_done1"}, b_if.append_done, 0);
    endtask

    // One append attempt on both DUTs, spanning 3 cycles:
    // append sampled at T, busy at T+1, done at T+2, then a read-back of the newest step.
    // The T+1 read targets the index being written, so it must return 0.
    task automatic app();
        int unsigned n0, n1;
        bit          a0, a1;
        logic [1:0]  c0;
        logic [2:0]  c1;
        logic [3:0]  e0;
        logic [7:0]  e1;
        n0 = q0.size();
        n1 = q1.size();
        a0 = (n0 < 32);
        a1 = (n1 < 256);
        c0 = m_lfsr[1:0];
        c1 = m_lfsr[2:0];
        if (n0 >= 2 && c0 == q0[n0-1] && c0 == q0[n0-2]) c0 = c0 + 2'd1;
        a_if.append = 1'b1;
        b_if.append = 1'b1;
        tick();
        a_if.append = 1'b0;
        b_if.append = 1'b0;
        chk("busy0", a_if.busy, a0);
        chk("busy1", b_if.busy, a1);
        a_if.rd_addr = 5'(n0);
        b_if.rd_addr = 8'(n1);
        e0 = er0(n0 % 32);
        e1 = er1(n1 % 256);
        tick();
        chk("done0", a_if.append_done, a0);
        chk("done1", b_if.append_done, a1);
        chk("len0",  a_if.seq_len, n0 + a0);
        chk("len1",  b_if.seq_len, n1 + a1);
        chk("full0", a_if.full, (n0 + a0) == 32);
        chk("full1", b_if.full, (n1 + a1) == 256);
        chk("rdwr0", a_if.rd_color, e0);
        chk("rdwr1", b_if.rd_color, e1);
        if (a0) q0.push_back(c0);
        if (a1) q1.push_back(c1);
        a_if.rd_addr = 5'(q0.size() - 1);
        b_if.rd_addr = 8'(q1.size() - 1);
        tick();
        chk("rdnew0", a_if.rd_color, er0(q0.size() - 1));
        chk("rdnew1", b_if.rd_color, er1(q1.size() - 1));
    endtask

    task automatic newgame();
        a_if.new_game = 1'b1;
        b_if.new_game = 1'b1;
        tick();
        a_if.new_game = 1'b0;
        b_if.new_game = 1'b0;
        chk("ng_len0",  a_if.seq_len, 0);
        chk("ng_full0", a_if.full, 0);
        chk("ng_len1",  b_if.seq_len, 0);
        chk("ng_full1", b_if.full, 0);
        q0.delete();
        q1.delete();
    endtask

    // Read back every step of both DUTs and look for colour triples in dut0
    task automatic sweep(input int unsigned n);
        logic [3:0] p1, p2, cur;
        p1 = '0;
        p2 = '0;
        for (int unsigned i = 0; i < n; i++) begin
            a_if.rd_addr = 5'(i);
            b_if.rd_addr = 8'(i);
            tick();
            chk("sw1", b_if.rd_color, er1(i));
            if (i < 32) begin
                cur = a_if.rd_color;
                chk("sw0", cur, er0(i));
                if (i >= 2) chk("triple0", (cur == p1 && cur == p2), 0);
                p2 = p1;
                p1 = cur;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_if.new_game = 1'b0; a_if.append = 1'b0; a_if.rd_addr = '0;
        b_if.new_game = 1'b0; b_if.append = 1'b0; b_if.rd_addr = '0;
        tick();
        tick();
        chk_idle_outputs("rst");
        chk("rst_lfsr", dut0.lfsr, 16'hACE1);
        rst = 1'b0;

        // Idle for 10 cycles: outputs stay 0 and the LFSRs track the model
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_lfsr0", dut0.lfsr, m_lfsr);
            chk("idle_lfsr1", dut1.lfsr, m_lfsr);
        end
        chk_idle_outputs("idle");

        // Single append
        app();

        // new_game during WRITE aborts the write, then an append together with new_game is ignored
        a_if.append = 1'b1; b_if.append = 1'b1;
        tick();
        a_if.append = 1'b0; b_if.append = 1'b0;
        chk("ab_busy0", a_if.busy, 1);
        a_if.new_game = 1'b1; b_if.new_game = 1'b1;
        tick();
        chk("ab_len0",  a_if.seq_len, 0);
        chk("ab_done0", a_if.append_done, 0);
        chk("ab_busy0b", a_if.busy, 0);
        chk("ab_done1", b_if.append_done, 0);
        a_if.append = 1'b1; b_if.append = 1'b1;
        tick();
        a_if.append = 1'b0; b_if.append = 1'b0;
        a_if.new_game = 1'b0; b_if.new_game = 1'b0;
        chk("ng_ap_busy0", a_if.busy, 0);
        chk("ng_ap_busy1", b_if.busy, 0);
        a_if.rd_addr = '0; b_if.rd_addr = '0;
        tick();
        chk("ng_ap_done0", a_if.append_done, 0);
        chk("ng_ap_len0",  a_if.seq_len, 0);
        chk("ng_rd0",      a_if.rd_color, 0);
        chk("ng_rd1",      b_if.rd_color, 0);
        q0.delete();
        q1.delete();

        // rst asserted during WRITE with seq_len = 5
        repeat (5) app();
        a_if.append = 1'b1; b_if.append = 1'b1;
        tick();
        a_if.append = 1'b0; b_if.append = 1'b0;
        chk("rw_busy0", a_if.busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle_outputs("rw");
        chk("rw_lfsr0", dut0.lfsr, 16'hACE1);
        chk("rw_lfsr1", dut1.lfsr, 16'hACE1);
        q0.delete();
        q1.delete();
        tick();
        chk("rw_len0b", a_if.seq_len, 0);
        chk("rw_done0", a_if.append_done, 0);

        // Long game: dut0 saturates at 32, dut1 saturates at 256, and the extra appends are ignored
        newgame();
        repeat (260) app();
        chk("sat_len0",  a_if.seq_len, 32);
        chk("sat_full0", a_if.full, 1);
        chk("sat_len1",  b_if.seq_len, 256);
        chk("sat_full1", b_if.full, 1);
        a_if.rd_addr = 5'd31;
        tick();
        chk("rd31", a_if.rd_color, er0(31));
        sweep(256);

        // Several more short games
        for (int g = 0; g < 3; g++) begin
            newgame();
            repeat (40) app();
            sweep(40);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
